// File: rtl/i2s_rx_pkg.sv
// rtl/i2s_rx_pkg.sv - shared FSM, channel and stereo-pair types for the I2S slave receiver
package i2s_rx_pkg;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Widest sample the pair container can carry; narrower samples occupy the low bits.
  localparam int PAIR_MAX_W = 32;

  typedef struct packed {
    logic [PAIR_MAX_W-1:0] left;
    logic [PAIR_MAX_W-1:0] right;
  } pair_t;

endpackage

// File: rtl/i2s_rx_sync.sv
// rtl/i2s_rx_sync.sv - input synchronizers for BCLK/LRCLK/SDATA plus BCLK rising-edge detect
module i2s_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic bclk_in,
  input  logic lrclk_in,
  input  logic sdata_in,
  output logic bclk_rise,
  output logic lr,
  output logic sdata
);

  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic                   bclk_prev_q, bclk_prev_d;

  // Shift each raw input one stage deeper; remember last synced BCLK for edge detection.
  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], bclk_in};
    lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], lrclk_in};
    sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], sdata_in};
    bclk_prev_d = bclk_sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-history registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      sd_sync_q   <= sd_sync_d;
      bclk_prev_q <= bclk_prev_d;
    end
  end

  // LRCLK and SDATA go through the same depth as BCLK, so they stay aligned to the detected edge.
  assign bclk_rise = bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
  assign lr        = lr_sync_q[SYNC_STAGES-1];
  assign sdata     = sd_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx_slave.sv
// rtl/i2s_rx_slave.sv - slave I2S deserializer with pair FIFO and AXI-Stream output; I2S_RX_LJ_EN adds left-justified mode
module i2s_rx_slave
  import i2s_rx_pkg::*;
#(
  parameter int DATA_W      = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          enable,
  input  logic                          bclk_in,
  input  logic                          lrclk_in,
  input  logic                          sdata_in,
`ifdef I2S_RX_LJ_EN
  input  logic                          lj_mode,
`endif
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] DATA_W_C = CW'(DATA_W);
  localparam logic [LW-1:0] DEPTH_C  = LW'(FIFO_DEPTH);

  logic bclk_rise, lr, sdata, lr_chg, prev_ch, lj;

  i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .bclk_in   (bclk_in),
    .lrclk_in  (lrclk_in),
    .sdata_in  (sdata_in),
    .bclk_rise (bclk_rise),
    .lr        (lr),
    .sdata     (sdata)
  );

  state_e             state_q, state_d;
  logic               lr_prev_q, lr_prev_d;
  logic [CW-1:0]      bit_cnt_q, bit_cnt_d, fin_cnt;
  logic [DATA_W-1:0]  word_q, word_d, fin_word;
  logic [DATA_W-1:0]  left_hold_q, left_hold_d;
  logic               left_valid_q, left_valid_d;
  logic               push_req;
  pair_t              push_pair;

`ifdef I2S_RX_LJ_EN
  logic lj_q, lj_d;

  // Format select is only taken while resynchronizing so a frame never changes format mid-stream.
  always_comb lj_d = (state_q == ST_SYNC) ? lj_mode : lj_q;

  // Format select register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lj_q <= 1'b0;
    else          lj_q <= lj_d;
  end

  assign lj = lj_q;
`else
  assign lj = 1'b0;
`endif

  // In left-justified mode LRCLK high means left, so XOR with lj maps the level to a channel.
  assign lr_chg  = (lr != lr_prev_q);
  assign prev_ch = lr_prev_q ^ lj;

  // Frame FSM: track word boundaries on BCLK rises, assemble words and hand complete pairs to the FIFO.
  always_comb begin
    state_d      = state_q;
    lr_prev_d    = lr_prev_q;
    bit_cnt_d    = bit_cnt_q;
    word_d       = word_q;
    left_hold_d  = left_hold_q;
    left_valid_d = left_valid_q;
    push_req     = 1'b0;
    push_pair    = '0;
    fin_word     = word_q;
    fin_cnt      = bit_cnt_q;
    if (bclk_rise) lr_prev_d = lr;
    if (!enable) begin
      state_d      = ST_SYNC;
      bit_cnt_d    = '0;
      word_d       = '0;
      left_valid_d = 1'b0;
    end else if (bclk_rise) begin
      case (state_q)
        ST_SYNC: begin
          if (lr_chg && ((lr ^ lj) == CH_LEFT)) begin
            state_d      = ST_RUN;
            left_valid_d = 1'b0;
            word_d       = lj ? DATA_W'(sdata) : '0;
            bit_cnt_d    = lj ? CW'(1) : '0;
          end
        end
        ST_RUN: begin
          if (!lr_chg) begin
            if (bit_cnt_q < DATA_W_C) begin
              word_d    = {word_q[DATA_W-2:0], sdata};
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end else begin
            // In I2S the bit at the LRCLK change still belongs to the word that is ending.
            if (!lj && (bit_cnt_q < DATA_W_C)) begin
              fin_word = {word_q[DATA_W-2:0], sdata};
              fin_cnt  = bit_cnt_q + CW'(1);
            end
            if (fin_cnt < DATA_W_C) fin_word = fin_word << (DATA_W_C - fin_cnt);
            word_d    = lj ? DATA_W'(sdata) : '0;
            bit_cnt_d = lj ? CW'(1) : '0;
            if (prev_ch == CH_LEFT) begin
              left_hold_d  = fin_word;
              left_valid_d = 1'b1;
            end else if ((prev_ch == CH_RIGHT) && left_valid_q) begin
              push_req                       = 1'b1;
              push_pair.left[DATA_W-1:0]     = left_hold_q;
              push_pair.right[DATA_W-1:0]    = fin_word;
              left_valid_d                   = 1'b0;
            end else begin
              // Right word without a preceding left word: frame is broken, resynchronize.
              state_d   = ST_SYNC;
              word_d    = '0;
              bit_cnt_d = '0;
            end
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end
  end

  // Frame FSM registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_SYNC;
      lr_prev_q    <= 1'b0;
      bit_cnt_q    <= '0;
      word_q       <= '0;
      left_hold_q  <= '0;
      left_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lr_prev_q    <= lr_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      word_q       <= word_d;
      left_hold_q  <= left_hold_d;
      left_valid_q <= left_valid_d;
    end
  end

  pair_t             fifo_mem_q [FIFO_DEPTH];
  pair_t             fifo_mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic              hs, pop, push_acc;

  // Pair FIFO and serializer: the head pair is only released once its right word is accepted,
  // so the pair being presented still counts toward fifo_level.
  always_comb begin
    hs         = tvalid_q && m_axis_tready;
    pop        = hs && tlast_q;
    push_acc   = push_req && ((level_q != DEPTH_C) || pop);
    overflow_d = (push_req && !push_acc) ? 1'b1 : (clear_overflow ? 1'b0 : overflow_q);
    fifo_mem_d = fifo_mem_q;
    if (push_acc) fifo_mem_d[wr_ptr_q] = push_pair;
    wr_ptr_d   = wr_ptr_q + AW'(push_acc);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    rd_next    = rd_ptr_q + AW'(1);
    level_d    = level_q + LW'(push_acc) - LW'(pop);
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tdata_d    = tdata_q;
    if (!tvalid_q) begin
      if (level_q != '0) begin
        tvalid_d = 1'b1;
        tlast_d  = 1'b0;
        tdata_d  = fifo_mem_q[rd_ptr_q].left[DATA_W-1:0];
      end
    end else if (hs) begin
      if (!tlast_q) begin
        tlast_d = 1'b1;
        tdata_d = fifo_mem_q[rd_ptr_q].right[DATA_W-1:0];
      end else if (level_q > LW'(1)) begin
        tlast_d = 1'b0;
        tdata_d = fifo_mem_q[rd_next].left[DATA_W-1:0];
      end else begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    end
  end

  // FIFO storage, pointers, status and output beat registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fifo_mem_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign fifo_level    = level_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_i2s_rx_slave.sv
// tb/tb_i2s_rx_slave.sv - directed scoreboard bench for the I2S slave receiver
module tb_i2s_rx_slave;

  localparam int DATA_W      = 24;
  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int LW          = $clog2(FIFO_DEPTH) + 1;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              enable = 1'b0;
  logic              bclk_in = 1'b0;
  logic              lrclk_in = 1'b1;
  logic              sdata_in = 1'b0;
  logic              m_axis_tready = 1'b0;
  logic              clear_overflow = 1'b0;
`ifdef I2S_RX_LJ_EN
  logic              lj_mode = 1'b0;
`endif
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic [LW-1:0]     fifo_level;
  logic              overflow;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  logic  carry = 1'b0;
  int    skip_first = 0;

  i2s_rx_slave #(
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .enable         (enable),
    .bclk_in        (bclk_in),
    .lrclk_in       (lrclk_in),
    .sdata_in       (sdata_in),
`ifdef I2S_RX_LJ_EN
    .lj_mode        (lj_mode),
`endif
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One BCLK period = 16 aclk; data and LRCLK change while BCLK is low.
  task automatic bit_slot(input logic lr, input logic d);
    bclk_in  = 1'b0;
    lrclk_in = lr;
    sdata_in = d;
    #80;
    bclk_in = 1'b1;
    #80;
  endtask

  // I2S channel segment of s slots carrying an n-bit word MSB first after the one-slot delay.
  task automatic send_range(input logic lr, input logic [31:0] w, input int n, input int s,
                            input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      if (k == 0)                 bit_slot(lr, carry);
      else if (k <= n && k < s)   bit_slot(lr, w[n-k]);
      else                        bit_slot(lr, 1'b0);
    end
    if (hi == s) carry = (n == s) ? w[0] : 1'b0;
  endtask

  task automatic send_seg(input logic lr, input logic [31:0] w, input int n, input int s);
    send_range(lr, w, n, s, skip_first, s);
    skip_first = 0;
  endtask

  // First slot of the next left segment: closes the pending right word.
  task automatic flush();
    bit_slot(1'b0, carry);
    carry = 1'b0;
    skip_first = 1;
  endtask

  task automatic exp_pair(input logic [31:0] l, input logic [31:0] r, input int n);
    beat_t b;
    b.data = DATA_W'(l << (DATA_W - n));
    b.last = 1'b0;
    exp_q.push_back(b);
    b.data = DATA_W'(r << (DATA_W - n));
    b.last = 1'b1;
    exp_q.push_back(b);
  endtask

  task automatic set_ready(input logic v);
    @(posedge aclk);
    #1 m_axis_tready = v;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge aclk);
      n++;
    end
    repeat (4) @(negedge aclk);
    check({tag, " pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, " tvalid idle"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, " level empty"}, 32'(fifo_level), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, " tdata"}, 32'(m_axis_tdata), 32'd0);
    check({tag, " tlast"}, 32'(m_axis_tlast), 32'd0);
    check({tag, " level"}, 32'(fifo_level), 32'd0);
    check({tag, " overflow"}, 32'(overflow), 32'd0);
  endtask

  // Scoreboard: every accepted beat is compared with the oldest expected beat.
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      check("beat expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat tdata", 32'(m_axis_tdata), 32'(b.data));
        check("beat tlast", 32'(m_axis_tlast), 32'(b.last));
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("reset");
    @(posedge aclk);
    #1 aresetn = 1'b1;
    enable = 1'b1;
    m_axis_tready = 1'b1;

    // Standard 24-bit I2S, 32 slots per channel.
    send_seg(1'b1, 32'h0, 24, 32);
    exp_pair(32'hA5A5A5, 32'h5A5A5A, 24);
    send_seg(1'b0, 32'hA5A5A5, 24, 32);
    send_seg(1'b1, 32'h5A5A5A, 24, 32);
    flush();
    wait_drain("i2s24");

    // 16-bit words in 16-slot channels: LSBs ride in the next channel's first slot.
    exp_pair(32'h1234, 32'hABCD, 16);
    send_seg(1'b0, 32'h1234, 16, 16);
    send_seg(1'b1, 32'hABCD, 16, 16);
    flush();
    wait_drain("short16");

    // Back-pressure: five pairs into a four-deep FIFO, the fifth is dropped.
    set_ready(1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_pair(32'hC00000 + 32'(i * 32'h010203), 32'h300000 + 32'(i * 32'h030201), 24);
      send_seg(1'b0, 32'hC00000 + 32'(i * 32'h010203), 24, 32);
      send_seg(1'b1, 32'h300000 + 32'(i * 32'h030201), 24, 32);
    end
    flush();
    repeat (10) @(negedge aclk);
    check("bp level full", 32'(fifo_level), 32'd4);
    check("bp overflow set", 32'(overflow), 32'd1);
    check("bp first left held", 32'(m_axis_tdata), 32'hC00000);
    set_ready(1'b1);
    wait_drain("bp drain");
    check("bp overflow sticky", 32'(overflow), 32'd1);
    @(posedge aclk);
    #1 clear_overflow = 1'b1;
    @(posedge aclk);
    #1 clear_overflow = 1'b0;
    @(negedge aclk);
    check("bp overflow cleared", 32'(overflow), 32'd0);

    // Enable dropped mid right word: that pair is lost, the next frame pairs correctly.
    send_seg(1'b0, 32'h333333, 24, 32);
    send_range(1'b1, 32'h444444, 24, 32, 0, 10);
    enable = 1'b0;
    repeat (20) @(posedge aclk);
    #1 enable = 1'b1;
    send_range(1'b1, 32'h444444, 24, 32, 10, 32);
    exp_pair(32'h765432, 32'h89ABCD, 24);
    send_seg(1'b0, 32'h765432, 24, 32);
    send_seg(1'b1, 32'h89ABCD, 24, 32);
    flush();
    wait_drain("enable");

    // Reset mid-word with a pair waiting at the output.
    set_ready(1'b0);
    send_seg(1'b0, 32'h121212, 24, 32);
    send_seg(1'b1, 32'h343434, 24, 32);
    flush();
    repeat (10) @(negedge aclk);
    check("pre-reset tvalid", 32'(m_axis_tvalid), 32'd1);
    check("pre-reset level", 32'(fifo_level), 32'd1);
    send_range(1'b0, 32'h555555, 24, 32, 1, 13);
    aresetn = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("midreset");
    @(posedge aclk);
    #1 aresetn = 1'b1;
    m_axis_tready = 1'b1;
    send_range(1'b0, 32'h555555, 24, 32, 13, 32);
    send_seg(1'b1, 32'h666666, 24, 32);
    exp_pair(32'h0F0F0F, 32'hF0F0F0, 24);
    send_seg(1'b0, 32'h0F0F0F, 24, 32);
    send_seg(1'b1, 32'hF0F0F0, 24, 32);
    flush();
    wait_drain("after reset");

`ifdef I2S_RX_LJ_EN
    // Left-justified: LRCLK high = left, MSB in the slot where LRCLK changes.
    enable = 1'b0;
    lj_mode = 1'b1;
    repeat (4) @(posedge aclk);
    #1 enable = 1'b1;
    for (int k = 0; k < 32; k++) bit_slot(1'b0, 1'b0);
    exp_pair(32'h800001, 32'h7FFFFF, 24);
    for (int k = 0; k < 32; k++) bit_slot(1'b1, (k < 24) ? 1'(32'h800001 >> (23 - k)) : 1'b0);
    for (int k = 0; k < 32; k++) bit_slot(1'b0, (k < 24) ? 1'(32'h7FFFFF >> (23 - k)) : 1'b0);
    bit_slot(1'b1, 1'b0);
    wait_drain("lj");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
